// File: rtl/clk_monitor.sv
// Measures period and high time of a slow square wave in clkin cycles, and raises
// a lock flag after consecutive in-tolerance periods and a sticky timeout on stall.
module clk_monitor #(
  parameter int clk_freq        = 1000,
  parameter int expected_period = 50000000 / clk_freq,
  parameter int tol             = 2,
  parameter int lock_count      = 4,
  parameter int timeout_cycles  = 4 * expected_period
) (
  input  logic        clkin,
  input  logic        rst,
  input  logic        en,
  input  logic        sig_in,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic        meas_valid,
  output logic        locked,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [32:0] lo_bound    = (expected_period > tol) ? 33'(expected_period - tol) : 33'd0;
  localparam logic [32:0] hi_bound    = 33'(expected_period) + 33'(tol);
  localparam logic [31:0] stall_limit = 32'(timeout_cycles);
  localparam logic [3:0]  lock_target = 4'(lock_count);

  state_t      state, state_next;
  logic        s1, s2, s3;
  logic        rise, fall;
  logic [31:0] cnt, cnt_inc;
  logic [3:0]  match_cnt, match_next;
  logic        in_tol, stalled;

  assign rise       = s2 & ~s3;
  assign fall       = ~s2 & s3;
  assign cnt_inc    = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  assign in_tol     = (cnt != 32'hFFFF_FFFF) && ({1'b0, cnt} >= lo_bound) && ({1'b0, cnt} <= hi_bound);
  assign match_next = (match_cnt < lock_target) ? match_cnt + 4'd1 : match_cnt;
  // A rise may still land on count timeout_cycles; the stall fires one count later.
  assign stalled    = (state == RUN) && !rise && (cnt >= stall_limit);

  always_ff @(posedge clkin) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = ARM;
        ARM:     if (rise) state_next = RUN;
        RUN:     if (stalled) state_next = ARM;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
      cnt        <= '0;
      match_cnt  <= '0;
    end else begin
      meas_valid <= 1'b0;
      if (!en) begin
        // Disabling discards lock and stall state but keeps the last measurement.
        locked    <= 1'b0;
        timeout   <= 1'b0;
        match_cnt <= '0;
        cnt       <= '0;
      end else begin
        case (state)
          ARM: begin
            if (rise) begin
              cnt     <= 32'd1;
              timeout <= 1'b0;
            end
          end
          RUN: begin
            if (rise) begin
              period     <= cnt;
              meas_valid <= 1'b1;
              cnt        <= 32'd1;
              if (in_tol) begin
                match_cnt <= match_next;
                locked    <= (match_next == lock_target);
              end else begin
                match_cnt <= '0;
                locked    <= 1'b0;
              end
            end else if (stalled) begin
              timeout   <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              cnt       <= '0;
            end else begin
              cnt <= cnt_inc;
              if (fall) high_time <= cnt;
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// Self-checking bench for clk_monitor: drives square waves period by period and
// compares each measurement against a timestamp-level model of the monitor.
module tb_clk_monitor;

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sig_in = 1'b0;
  logic [31:0] period, high_time;
  logic        meas_valid, locked, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: whether the next rise is the first one, the last driven period and
  // high time, the run of consecutive good periods, and a pending stall flag.
  bit m_first     = 1'b1;
  int m_prev_p    = 0;
  int m_prev_h    = 0;
  int m_streak    = 0;
  bit m_timed_out = 1'b0;

  clk_monitor #(
    .clk_freq(5000000),
    .tol(1),
    .lock_count(4),
    .timeout_cycles(40)
  ) dut (
    .clkin(clkin),
    .rst(rst),
    .en(en),
    .sig_in(sig_in),
    .period(period),
    .high_time(high_time),
    .meas_valid(meas_valid),
    .locked(locked),
    .timeout(timeout)
  );

  always #10 clkin = ~clkin;

  // Predicts what the monitor reports three cycles after a rise starting a period (p, h).
  function automatic void model_rise(input int p, input int h, output logic e_mv,
                                     output logic [31:0] e_per, output logic [31:0] e_ht,
                                     output logic e_lk, output logic e_early);
    int d;
    e_mv = 1'b0;
    e_per = '0;
    e_ht = '0;
    e_early = m_timed_out;
    if (!m_first && m_prev_p > 40) begin
      e_early = 1'b1;
      m_streak = 0;
    end else if (!m_first) begin
      e_mv = 1'b1;
      e_per = 32'(m_prev_p);
      e_ht = 32'(m_prev_h);
      d = m_prev_p - 10;
      if (d >= -1 && d <= 1) m_streak++;
      else m_streak = 0;
    end
    e_lk = (m_streak >= 4);
    m_first = 1'b0;
    m_timed_out = 1'b0;
    m_prev_p = p;
    m_prev_h = h;
  endfunction

  task automatic drive_period(input int p, input int h, output logic mv, output logic [31:0] per,
                              output logic [31:0] ht, output logic lk, output logic to,
                              output logic early_to, output int pulses);
    pulses = 0;
    early_to = 1'b0;
    mv = 1'b0;
    per = '0;
    ht = '0;
    lk = 1'b0;
    to = 1'b0;
    sig_in = 1'b1;
    for (int i = 1; i <= p; i++) begin
      @(negedge clkin);
      if (meas_valid === 1'b1) pulses++;
      if (i <= 2 && timeout === 1'b1) early_to = 1'b1;
      if (i == 3) begin
        mv = meas_valid;
        per = period;
        ht = high_time;
        lk = locked;
        to = timeout;
      end
      if (i == h) sig_in = 1'b0;
    end
  endtask

  task automatic settle_low(input int n);
    sig_in = 1'b0;
    repeat (n) @(negedge clkin);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clkin);
      n_checks++;
      if ({period, high_time, meas_valid, locked, timeout} !== 67'd0) begin
        n_fail++;
        $display("[TB] FAIL reset[%0d]: got per=%0d ht=%0d mv=%b lk=%b to=%b, expected all zero",
                 i, period, high_time, meas_valid, locked, timeout);
      end
      sig_in = ~sig_in;
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clkin);
      n_checks++;
      if ({period, high_time, meas_valid, locked, timeout} !== 67'd0) begin
        n_fail++;
        $display("[TB] FAIL idle[%0d]: got per=%0d ht=%0d mv=%b lk=%b to=%b, expected all zero",
                 i, period, high_time, meas_valid, locked, timeout);
      end
      if (i % 3 == 2) sig_in = ~sig_in;
    end
  endtask

  task automatic test_ideal();
    logic mv, lk, to, early, e_mv, e_lk, e_early;
    logic [31:0] per, ht, e_per, e_ht;
    int pulses;
    en = 1'b1;
    settle_low(4);
    m_first = 1'b1;
    m_streak = 0;
    for (int k = 0; k < 6; k++) begin
      model_rise(10, 5, e_mv, e_per, e_ht, e_lk, e_early);
      drive_period(10, 5, mv, per, ht, lk, to, early, pulses);
      n_checks++;
      if (mv !== e_mv || to !== 1'b0 || lk !== e_lk || early !== e_early || pulses != (e_mv ? 1 : 0) ||
          (e_mv && (per !== e_per || ht !== e_ht))) begin
        n_fail++;
        $display("[TB] FAIL ideal[%0d]: got mv=%b per=%0d ht=%0d lk=%b to=%b early_to=%b pulses=%0d, expected mv=%b per=%0d ht=%0d lk=%b to=0 early_to=%b",
                 k, mv, per, ht, lk, to, early, pulses, e_mv, e_per, e_ht, e_lk, e_early);
      end
    end
  endtask

  task automatic test_tolerance();
    int plist[12] = '{15, 9, 11, 11, 9, 12, 10, 10, 10, 10, 10, 10};
    logic mv, lk, to, early, e_mv, e_lk, e_early;
    logic [31:0] per, ht, e_per, e_ht;
    int pulses;
    for (int k = 0; k < 12; k++) begin
      model_rise(plist[k], 4, e_mv, e_per, e_ht, e_lk, e_early);
      drive_period(plist[k], 4, mv, per, ht, lk, to, early, pulses);
      n_checks++;
      if (mv !== e_mv || to !== 1'b0 || lk !== e_lk || early !== e_early || pulses != (e_mv ? 1 : 0) ||
          (e_mv && (per !== e_per || ht !== e_ht))) begin
        n_fail++;
        $display("[TB] FAIL tolerance[%0d]: got mv=%b per=%0d ht=%0d lk=%b to=%b early_to=%b pulses=%0d, expected mv=%b per=%0d ht=%0d lk=%b to=0 early_to=%b",
                 k, mv, per, ht, lk, to, early, pulses, e_mv, e_per, e_ht, e_lk, e_early);
      end
    end
  endtask

  task automatic test_stall();
    logic mv, lk, to, early, e_mv, e_lk, e_early;
    logic [31:0] per, ht, e_per, e_ht;
    int pulses;
    for (int k = 0; k < 7; k++) begin
      model_rise(10, 5, e_mv, e_per, e_ht, e_lk, e_early);
      drive_period(10, 5, mv, per, ht, lk, to, early, pulses);
      n_checks++;
      if (mv !== e_mv || to !== 1'b0 || lk !== e_lk || early !== e_early || pulses != (e_mv ? 1 : 0) ||
          (e_mv && (per !== e_per || ht !== e_ht))) begin
        n_fail++;
        $display("[TB] FAIL stall_pre[%0d]: got mv=%b per=%0d ht=%0d lk=%b to=%b early_to=%b pulses=%0d, expected mv=%b per=%0d ht=%0d lk=%b to=0 early_to=%b",
                 k, mv, per, ht, lk, to, early, pulses, e_mv, e_per, e_ht, e_lk, e_early);
      end
    end
    // The last rise was driven 10 negedges ago; the monitor acts on it 3 cycles after driving.
    for (int i = 11; i <= 47; i++) begin
      @(negedge clkin);
      if (i == 42) begin
        n_checks++;
        if (timeout !== 1'b0 || locked !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL stall_before: got to=%b lk=%b, expected to=0 lk=1", timeout, locked);
        end
      end
      if (i == 43) begin
        n_checks++;
        if (timeout !== 1'b1 || locked !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL stall_fire: got to=%b lk=%b, expected to=1 lk=0", timeout, locked);
        end
      end
      if (i == 47) begin
        n_checks++;
        if (timeout !== 1'b1 || meas_valid !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL stall_sticky: got to=%b mv=%b, expected to=1 mv=0", timeout, meas_valid);
        end
      end
    end
    m_first = 1'b1;
    m_streak = 0;
    m_timed_out = 1'b1;
    for (int k = 0; k < 2; k++) begin
      model_rise(10, 5, e_mv, e_per, e_ht, e_lk, e_early);
      drive_period(10, 5, mv, per, ht, lk, to, early, pulses);
      n_checks++;
      if (mv !== e_mv || to !== 1'b0 || lk !== e_lk || early !== e_early || pulses != (e_mv ? 1 : 0) ||
          (e_mv && (per !== e_per || ht !== e_ht))) begin
        n_fail++;
        $display("[TB] FAIL stall_resume[%0d]: got mv=%b per=%0d ht=%0d lk=%b to=%b early_to=%b pulses=%0d, expected mv=%b per=%0d ht=%0d lk=%b to=0 early_to=%b",
                 k, mv, per, ht, lk, to, early, pulses, e_mv, e_per, e_ht, e_lk, e_early);
      end
    end
  endtask

  task automatic test_en_drop();
    logic mv, lk, to, early, e_mv, e_lk, e_early;
    logic [31:0] per, ht, e_per, e_ht;
    int pulses;
    for (int k = 0; k < 8; k++) begin
      if (k == 5) begin
        // Partial period: drop en after the measurement, before this period's fall is acted on.
        model_rise(10, 4, e_mv, e_per, e_ht, e_lk, e_early);
        sig_in = 1'b1;
        for (int i = 1; i <= 7; i++) begin
          @(negedge clkin);
          if (i == 3) begin
            n_checks++;
            if (meas_valid !== e_mv || period !== e_per || locked !== e_lk || timeout !== 1'b0) begin
              n_fail++;
              $display("[TB] FAIL en_partial: got mv=%b per=%0d lk=%b to=%b, expected mv=%b per=%0d lk=%b to=0",
                       meas_valid, period, locked, timeout, e_mv, e_per, e_lk);
            end
          end
          if (i == 6) sig_in = 1'b0;
        end
        en = 1'b0;
        for (int j = 0; j < 30; j++) begin
          @(negedge clkin);
          n_checks++;
          if (meas_valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0 || period !== 32'd10 || high_time !== 32'd4) begin
            n_fail++;
            $display("[TB] FAIL en_off[%0d]: got mv=%b lk=%b to=%b per=%0d ht=%0d, expected mv=0 lk=0 to=0 per=10 ht=4",
                     j, meas_valid, locked, timeout, period, high_time);
          end
          sig_in = ((j / 5) % 2 == 0);
        end
        sig_in = 1'b0;
        en = 1'b1;
        settle_low(4);
        m_first = 1'b1;
        m_streak = 0;
        m_timed_out = 1'b0;
      end else begin
        model_rise(10, 4, e_mv, e_per, e_ht, e_lk, e_early);
        drive_period(10, 4, mv, per, ht, lk, to, early, pulses);
        n_checks++;
        if (mv !== e_mv || to !== 1'b0 || lk !== e_lk || early !== e_early || pulses != (e_mv ? 1 : 0) ||
            (e_mv && (per !== e_per || ht !== e_ht))) begin
          n_fail++;
          $display("[TB] FAIL en_drop[%0d]: got mv=%b per=%0d ht=%0d lk=%b to=%b early_to=%b pulses=%0d, expected mv=%b per=%0d ht=%0d lk=%b to=0 early_to=%b",
                   k, mv, per, ht, lk, to, early, pulses, e_mv, e_per, e_ht, e_lk, e_early);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int plist[6] = '{10, 40, 10, 41, 10, 10};
    logic mv, lk, to, early, e_mv, e_lk, e_early;
    logic [31:0] per, ht, e_per, e_ht;
    int pulses;
    for (int k = 0; k < 6; k++) begin
      model_rise(plist[k], 6, e_mv, e_per, e_ht, e_lk, e_early);
      drive_period(plist[k], 6, mv, per, ht, lk, to, early, pulses);
      n_checks++;
      if (mv !== e_mv || to !== 1'b0 || lk !== e_lk || early !== e_early || pulses != (e_mv ? 1 : 0) ||
          (e_mv && (per !== e_per || ht !== e_ht))) begin
        n_fail++;
        $display("[TB] FAIL simultaneous[%0d]: got mv=%b per=%0d ht=%0d lk=%b to=%b early_to=%b pulses=%0d, expected mv=%b per=%0d ht=%0d lk=%b to=0 early_to=%b",
                 k, mv, per, ht, lk, to, early, pulses, e_mv, e_per, e_ht, e_lk, e_early);
      end
    end
    @(negedge clkin);
    rst = 1'b1;
    sig_in = 1'b0;
    @(negedge clkin);
    n_checks++;
    if ({period, high_time, meas_valid, locked, timeout} !== 67'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_run: got per=%0d ht=%0d mv=%b lk=%b to=%b, expected all zero",
               period, high_time, meas_valid, locked, timeout);
    end
    rst = 1'b0;
    settle_low(4);
    m_first = 1'b1;
    m_streak = 0;
    m_timed_out = 1'b0;
  endtask

  task automatic test_random();
    logic mv, lk, to, early, e_mv, e_lk, e_early;
    logic [31:0] per, ht, e_per, e_ht;
    int pulses, p, h;
    for (int k = 0; k < 60; k++) begin
      p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 44)) : int'($urandom_range(8, 12));
      h = int'($urandom_range(1, (p - 1 < 30) ? p - 1 : 30));
      model_rise(p, h, e_mv, e_per, e_ht, e_lk, e_early);
      drive_period(p, h, mv, per, ht, lk, to, early, pulses);
      n_checks++;
      if (mv !== e_mv || to !== 1'b0 || lk !== e_lk || early !== e_early || pulses != (e_mv ? 1 : 0) ||
          (e_mv && (per !== e_per || ht !== e_ht))) begin
        n_fail++;
        $display("[TB] FAIL random[%0d] p=%0d h=%0d: got mv=%b per=%0d ht=%0d lk=%b to=%b early_to=%b pulses=%0d, expected mv=%b per=%0d ht=%0d lk=%b to=0 early_to=%b",
                 k, p, h, mv, per, ht, lk, to, early, pulses, e_mv, e_per, e_ht, e_lk, e_early);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_tolerance();
    test_stall();
    test_en_drop();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before the end of the sequence");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
